// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM state codes, the key map
// and a lookup helper used by the decoder.
package keypad_pkg;

    localparam logic [2:0] ST_SCAN     = 3'd0;
    localparam logic [2:0] ST_DEBOUNCE = 3'd1;
    localparam logic [2:0] ST_ACCEPT   = 3'd2;
    localparam logic [2:0] ST_HOLD     = 3'd3;
    localparam logic [2:0] ST_RELEASE  = 3'd4;

    localparam logic [3:0] ROWS_IDLE = 4'b1111;
    localparam logic [3:0] COL_FIRST = 4'b1110;

    // Row-major nibbles, key (row r, col c) lives at nibble r*4+c:
    // 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    function automatic logic [3:0] key_lookup(input logic [1:0] row_idx,
                                              input logic [1:0] col_idx);
        logic [5:0] bit_base;
        bit_base = {row_idx, col_idx, 2'b00};
        return KEY_MAP[bit_base +: 4];
    endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational decode of an active-low one-hot row/column pair into a hex key.
// valid is low whenever either input is not exactly one bit low.
module keypad_decode
    import keypad_pkg::*;
(
    input  logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key,
    output logic       valid
);

    logic [1:0] row_idx;
    logic [1:0] col_idx;
    logic       row_ok;
    logic       col_ok;

    always_comb begin
        row_idx = 2'd0;
        row_ok  = 1'b1;
        case (row)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_ok  = 1'b0;
        endcase
    end

    always_comb begin
        col_idx = 2'd0;
        col_ok  = 1'b1;
        case (col)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_ok  = 1'b0;
        endcase
    end

    assign key   = key_lookup(row_idx, col_idx);
    assign valid = row_ok && col_ok;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive on a slow tick,
// debounces press and release, and shifts each accepted key into a 2-digit value.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 48000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [7:0] digits,
    output logic       new_key
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT + 1) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_CNT);

    logic [3:0]       rows_meta;
    logic [3:0]       rows_s;
    logic [DIV_W-1:0] div_count;
    logic             tick;
    logic [2:0]       state;
    logic [3:0]       row_lat;
    logic [3:0]       key_lat;
    logic [DB_W-1:0]  db_count;
    logic [DB_W-1:0]  db_next;
    logic [3:0]       hit_key;
    logic             hit_valid;
    logic [3:0]       cols_rot;

    // rows come straight off the keypad pins, so nothing downstream sees them unsynchronized
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows_meta <= ROWS_IDLE;
            rows_s    <= ROWS_IDLE;
        end else begin
            rows_meta <= rows;
            rows_s    <= rows_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_count <= '0;
        end else if (div_count == DIV_LAST) begin
            div_count <= '0;
        end else begin
            div_count <= div_count + 1'b1;
        end
    end

    assign tick     = (div_count == DIV_LAST);
    assign db_next  = db_count + 1'b1;
    assign cols_rot = {cols[2:0], cols[3]};

    // Decoding the live rows against the driven column also detects multi-key
    // presses: anything other than a single low row comes back invalid.
    keypad_decode u_decode (
        .row   (rows_s),
        .col   (cols),
        .key   (hit_key),
        .valid (hit_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_SCAN;
            cols     <= COL_FIRST;
            row_lat  <= ROWS_IDLE;
            key_lat  <= 4'h0;
            db_count <= '0;
            digits   <= 8'h00;
            new_key  <= 1'b0;
        end else begin
            new_key <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (tick) begin
                        if (rows_s != ROWS_IDLE && hit_valid) begin
                            row_lat  <= rows_s;
                            key_lat  <= hit_key;
                            db_count <= '0;
                            state    <= ST_DEBOUNCE;
                        end else begin
                            cols <= cols_rot;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (tick) begin
                        if (rows_s == row_lat) begin
                            db_count <= db_next;
                            if (db_next == DB_TARGET) begin
                                state <= ST_ACCEPT;
                            end
                        end else begin
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_ACCEPT: begin
                    digits  <= {digits[3:0], key_lat};
                    new_key <= 1'b1;
                    state   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (tick && rows_s == ROWS_IDLE) begin
                        db_count <= '0;
                        state    <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // cols stays parked on the pressed column so a bounce is seen as the same key
                    if (tick) begin
                        if (rows_s == ROWS_IDLE) begin
                            db_count <= db_next;
                            if (db_next == DB_TARGET) begin
                                state <= ST_SCAN;
                            end
                        end else begin
                            state <= ST_HOLD;
                        end
                    end
                end
                default: begin
                    state <= ST_SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: scenarios queue the digits value each
// accepted key should produce; a monitor pops and compares on every new_key pulse.
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [7:0]  digits;
    logic        new_key;
    logic [15:0] pressed = 16'h0000;

    int          compared = 0;
    int          mismatched = 0;
    logic [7:0]  exp_q[$];
    logic        prev_new_key = 1'b0;

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rows    (rows),
        .cols    (cols),
        .digits  (digits),
        .new_key (new_key)
    );

    always #5 clk = ~clk;

    // Passive keypad: a pressed key pulls its row low while its column is driven low
    always_comb begin
        rows = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !cols[c]) begin
                    rows[r] = 1'b0;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [7:0] actual,
                                input logic [7:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (new_key === 1'b1) begin
            check_output("pulse_width", {7'b0, prev_new_key}, 8'h00);
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_pulse: got pulse with digits=%h, expected no pulse at %0t",
                         digits, $time);
            end else begin
                check_output("digits_on_pulse", digits, exp_q.pop_front());
            end
        end
        prev_new_key = new_key;
    end

    task automatic run_ticks(input int n);
        repeat (n * SCAN_DIV) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [15:0] keys, input int ticks);
        pressed = keys;
        run_ticks(ticks);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_cols", {4'h0, cols}, 8'h0E);
        check_output("reset_digits", digits, 8'h00);
        check_output("reset_new_key", {7'b0, new_key}, 8'h00);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_col(input logic [3:0] target, input string name);
        int n;
        n = 0;
        while (cols !== target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (cols !== target) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: got cols=%b, expected %b within 200 cycles", name, cols, target);
        end
    endtask

    task automatic count_col_changes(input int cycles, output int changes);
        logic [3:0] prev;
        prev    = cols;
        changes = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (cols !== prev) changes++;
            prev = cols;
        end
    endtask

    task automatic check_drained(input string name);
        check_output(name, 8'(exp_q.size()), 8'h00);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] prev_cols;
        logic [3:0] exp_cols;
        int         last_change;
        int         changes;

        // Idle rotation right out of reset
        do_reset();
        prev_cols   = cols;
        exp_cols    = 4'b1110;
        last_change = 0;
        changes     = 0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(negedge clk);
            if (cols !== prev_cols) begin
                exp_cols = {exp_cols[2:0], exp_cols[3]};
                check_output("rotate_value", {4'h0, cols}, {4'h0, exp_cols});
                check_output("rotate_spacing", 8'(cyc - last_change), 8'd4);
                last_change = cyc;
                changes++;
            end
            prev_cols = cols;
        end
        check_output("rotate_count", 8'(changes), 8'd6);
        check_output("idle_digits", digits, 8'h00);

        // Key '5' then key '9'
        do_reset();
        exp_q.push_back(8'h05);
        apply_stimulus(16'h0001 << 5, 40);
        apply_stimulus(16'h0000, 20);
        exp_q.push_back(8'h59);
        apply_stimulus(16'h0001 << 10, 40);
        apply_stimulus(16'h0000, 20);
        check_drained("drain_5_9");
        check_output("final_59", digits, 8'h59);

        // Bouncy press of key '6' lined up with its column
        do_reset();
        exp_q.push_back(8'h06);
        wait_col(4'b1011, "wait_col2");
        apply_stimulus(16'h0001 << 6, 1);
        apply_stimulus(16'h0000, 1);
        apply_stimulus(16'h0001 << 6, 1);
        apply_stimulus(16'h0000, 1);
        apply_stimulus(16'h0001 << 6, 40);
        apply_stimulus(16'h0000, 20);
        check_drained("drain_bounce");
        check_output("final_bounce", digits, 8'h06);

        // Long hold of key '8' with a one-tick release glitch
        do_reset();
        exp_q.push_back(8'h08);
        apply_stimulus(16'h0001 << 9, 50);
        apply_stimulus(16'h0000, 1);
        apply_stimulus(16'h0001 << 9, 30);
        apply_stimulus(16'h0000, 20);
        check_drained("drain_glitch");
        check_output("final_glitch", digits, 8'h08);

        // Keys '1' and '4' together share column 0
        do_reset();
        pressed = (16'h0001 << 0) | (16'h0001 << 4);
        count_col_changes(32, changes);
        check_output("multikey_rotate", 8'(changes), 8'd8);
        apply_stimulus(pressed, 20);
        apply_stimulus(16'h0000, 10);
        check_drained("drain_multikey");
        check_output("final_multikey", digits, 8'h00);

        // Reset lands in DEBOUNCE after two stable ticks of key '5'
        do_reset();
        pressed = 16'h0001 << 5;
        wait_col(4'b1101, "wait_col1");
        repeat (12) @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("abort_cols", {4'h0, cols}, 8'h0E);
        check_output("abort_digits", digits, 8'h00);
        check_output("abort_new_key", {7'b0, new_key}, 8'h00);
        pressed = 16'h0000;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        run_ticks(30);
        check_drained("drain_abort");
        check_output("final_abort", digits, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 48000, giving clk cycles per scan tick (1 kHz at 48 MHz).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 20, giving consecutive stable ticks needed to accept a press or a release.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  system clock, 48 MHz HSOSC.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 rows  input  4  keypad rows, active-low, pulled up, asynchronous to clk.
REQ-007 cols  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-008 digits  output  8  display value to the display multiplexer: [7:4] previous key, [3:0] newest key.
REQ-009 new_key  output  1  one-cycle pulse when a press is accepted.

Function
REQ-010 SHALL pass rows through a 2-flop synchronizer (rows_s) before any use; only rows_s feeds the logic.
REQ-011 SHALL count clk 0..SCAN_DIV-1 and assert tick for one cycle when the count equals SCAN_DIV-1, then wrap to 0.
REQ-012 SHALL sample rows_s only on tick cycles; all FSM transitions occur on tick cycles, except the one-cycle ACCEPT state.
REQ-013 FSM states: SCAN, DEBOUNCE, ACCEPT, HOLD, RELEASE.
REQ-014 SCAN: with rows_s==4'b1111 on tick, SHALL rotate cols 1110->1101->1011->0111->1110.
REQ-015 SCAN: with exactly one rows_s bit low on tick, SHALL latch rows_s and col, zero the debounce count, hold cols, and go to DEBOUNCE.
REQ-016 SCAN: with two or more rows_s bits low on tick (multi-key), SHALL ignore the input and keep rotating cols.
REQ-017 DEBOUNCE: on tick with rows_s equal to the latched row, SHALL increment the count; at DEBOUNCE_CNT it SHALL go to ACCEPT.
REQ-018 DEBOUNCE: on tick with rows_s differing from the latched row, SHALL return to SCAN without a digit update.
REQ-019 ACCEPT, one cycle: SHALL update digits <= {digits[3:0], key}, pulse new_key, and go to HOLD.
REQ-020 HOLD: cols SHALL stay fixed; on tick with rows_s==4'b1111, SHALL zero the count and go to RELEASE.
REQ-021 RELEASE: on tick with rows_s==1111, SHALL increment the count and go to SCAN at DEBOUNCE_CNT; any low row SHALL return to HOLD with no new digit.
REQ-022 A second key pressed while in HOLD or RELEASE SHALL be ignored until the full release completes.
REQ-023 Key map, row-major, row0..3 x col0..3: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
REQ-024 Accept latency SHALL be DEBOUNCE_CNT+1 ticks from the first tick seeing the press, plus one clk cycle.

Reset
REQ-025 While reset is low, outputs SHALL be: cols=4'b1110, digits=8'h00, new_key=0.
REQ-026 While reset is low, internal state SHALL be: FSM=SCAN, tick counter=0, debounce count=0, synchronizer=4'b1111.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL abort immediately with no digit update; after reset deasserts, scanning restarts from column 0.

Structure
REQ-028 keypad_pkg SHALL hold the FSM state enum and the 4x4 key-map constant.
REQ-029 Sub-module keypad_decode SHALL be combinational: one-hot active-low row and col in, 4-bit hex key and valid out.
REQ-030 digits SHALL connect directly to the display multiplexer switch input, with no extra register.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-031 Reset, no key: cols cycles 1110,1101,1011,0111,1110, changing every 4 clk; digits=00; new_key never high.
REQ-032 Stable key '5' (row1, col1): digits 00->05, one new_key pulse; then key '9' after release: digits 59.
REQ-033 Bouncy press: row toggles on ticks 1-2 then holds; exactly one new_key pulse, digits=0X, X=key.
REQ-034 Held key for 50 ticks, then a 1-tick release glitch, then hold again: no second pulse, digits unchanged.
REQ-035 Two rows low in the same column (keys '1' and '4'): no pulse, cols keep rotating.
REQ-036 Reset asserted in DEBOUNCE after 2 stable ticks: cols=1110, digits=00 immediately; no pulse after release.
